// File: rtl/vx_fpu_pkg.sv
// Shared FPU encodings: rounding modes, fflags bit positions and the
// classifier's class-vector bit positions.
package vx_fpu_pkg;

    localparam logic [2:0] FRM_RNE = 3'd0;
    localparam logic [2:0] FRM_RTZ = 3'd1;
    localparam logic [2:0] FRM_RDN = 3'd2;
    localparam logic [2:0] FRM_RUP = 3'd3;
    localparam logic [2:0] FRM_RMM = 3'd4;

    localparam int FF_NV = 4;
    localparam int FF_DZ = 3;
    localparam int FF_OF = 2;
    localparam int FF_UF = 1;
    localparam int FF_NX = 0;

    localparam int CLASS_NORMAL    = 6;
    localparam int CLASS_ZERO      = 5;
    localparam int CLASS_SUBNORMAL = 4;
    localparam int CLASS_INF       = 3;
    localparam int CLASS_NAN       = 2;
    localparam int CLASS_QUIET     = 1;
    localparam int CLASS_SIGNALING = 0;

endpackage

// File: rtl/vx_fp_round.sv
// Rounding-increment decision from lsb/guard/round/sticky and rounding mode.
module vx_fp_round
    import vx_fpu_pkg::*;
(
    input  logic       sign_i,
    input  logic       lsb_i,
    input  logic       g_i,
    input  logic       r_i,
    input  logic       s_i,
    input  logic [2:0] frm_i,
    output logic       inc_o,
    output logic       inexact_o
);
    logic any;
    assign any       = g_i | r_i | s_i;
    assign inexact_o = any;

    // Reserved encodings fall through to round-to-nearest-even.
    always_comb begin
        inc_o = g_i & (r_i | s_i | lsb_i);
        case (frm_i)
            FRM_RTZ: inc_o = 1'b0;
            FRM_RDN: inc_o = sign_i & any;
            FRM_RUP: inc_o = !sign_i & any;
            FRM_RMM: inc_o = g_i;
            default: inc_o = g_i & (r_i | s_i | lsb_i);
        endcase
    end
endmodule

// File: rtl/vx_fp_pack.sv
// Packs an unpacked FP operand into an IEEE-754 word: stage 1 handles specials
// and denormalization, stage 2 rounds and packs. Elastic valid/ready on both ends.
module vx_fp_pack
    import vx_fpu_pkg::*;
#(
    parameter int EXP_BITS = 8,
    parameter int MAN_BITS = 23
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       valid_in,
    output logic                       ready_in,
    input  logic                       sign_in,
    input  logic [EXP_BITS+1:0]        exp_in,
    input  logic [MAN_BITS+3:0]        man_in,
    input  logic [6:0]                 class_in,
    input  logic [2:0]                 frm_in,
    output logic                       valid_out,
    input  logic                       ready_out,
    output logic [EXP_BITS+MAN_BITS:0] result_out,
    output logic [4:0]                 fflags_out
);
    localparam int EW = EXP_BITS + 2;
    localparam int MW = MAN_BITS + 4;
    localparam int FW = 1 + EXP_BITS + MAN_BITS;
    localparam int SW = EW + 1;

    typedef struct packed {
        logic          sign;
        logic [EW-1:0] exp;
        logic [MW-1:0] man;
        logic          special;
        logic [FW-1:0] spec_word;
        logic          nv;
        logic [2:0]    frm;
        logic          tiny;
    } s1_t;

    s1_t           s1_d, s1_q;
    logic [2:1]    vld_pipe_q;
    logic          s2_load;
    logic [FW-1:0] result_d, result_q;
    logic [4:0]    fflags_d, fflags_q;

    assign s2_load    = !vld_pipe_q[2] || ready_out;
    assign ready_in   = !vld_pipe_q[1] || s2_load;
    assign valid_out  = vld_pipe_q[2];
    assign result_out = result_q;
    assign fflags_out = fflags_q;

    // One extra bit so 1-exp_in cannot wrap for the most negative exponent.
    logic signed [SW-1:0] shamt;
    logic [SW-1:0]        keep_sh;
    logic [MW-1:0]        lost_bits;
    assign shamt     = $signed(SW'(1)) - $signed({exp_in[EW-1], exp_in});
    assign keep_sh   = SW'(MW) - $unsigned(shamt);
    assign lost_bits = man_in << keep_sh;

    always_comb begin
        s1_d      = '0;
        s1_d.sign = sign_in;
        s1_d.exp  = exp_in;
        s1_d.man  = man_in;
        s1_d.frm  = frm_in;
        if (class_in[CLASS_NAN]) begin
            s1_d.special   = 1'b1;
            s1_d.spec_word = {1'b0, {EXP_BITS{1'b1}}, 1'b1, {(MAN_BITS-1){1'b0}}};
            s1_d.nv        = class_in[CLASS_SIGNALING];
        end else if (class_in[CLASS_INF]) begin
            s1_d.special   = 1'b1;
            s1_d.spec_word = {sign_in, {EXP_BITS{1'b1}}, {MAN_BITS{1'b0}}};
        end else if (class_in[CLASS_ZERO]) begin
            s1_d.special   = 1'b1;
            s1_d.spec_word = {sign_in, {(FW-1){1'b0}}};
        end else if (exp_in[EW-1] || exp_in == '0) begin
            s1_d.tiny = 1'b1;
            s1_d.exp  = '0;
            if (shamt >= $signed(SW'(MW)))
                s1_d.man = {{(MW-1){1'b0}}, |man_in};
            else
                s1_d.man = (man_in >> shamt) | {{(MW-1){1'b0}}, |lost_bits};
        end
    end

    logic                inc, inexact, carry, of, to_inf;
    logic [MAN_BITS-1:0] frac_r;
    logic [EW-1:0]       exp_r;

    vx_fp_round u_round (
        .sign_i    (s1_q.sign),
        .lsb_i     (s1_q.man[3]),
        .g_i       (s1_q.man[2]),
        .r_i       (s1_q.man[1]),
        .s_i       (s1_q.man[0]),
        .frm_i     (s1_q.frm),
        .inc_o     (inc),
        .inexact_o (inexact)
    );

    assign {carry, frac_r} = {1'b0, s1_q.man[MW-2:3]} + {{MAN_BITS{1'b0}}, inc};
    // A subnormal that rounds into the hidden bit becomes the smallest normal.
    assign exp_r = !carry          ? s1_q.exp :
                   s1_q.man[MW-1]  ? s1_q.exp + EW'(1) : EW'(1);
    assign of    = $signed(exp_r) >= $signed(EW'((1 << EXP_BITS) - 1));

    always_comb begin
        case (s1_q.frm)
            FRM_RTZ: to_inf = 1'b0;
            FRM_RDN: to_inf = s1_q.sign;
            FRM_RUP: to_inf = !s1_q.sign;
            default: to_inf = 1'b1;
        endcase
    end

    always_comb begin
        result_d        = {s1_q.sign, exp_r[EXP_BITS-1:0], frac_r};
        fflags_d        = '0;
        fflags_d[FF_NX] = inexact;
        fflags_d[FF_UF] = s1_q.tiny & inexact;
        if (s1_q.special) begin
            result_d        = s1_q.spec_word;
            fflags_d        = '0;
            fflags_d[FF_NV] = s1_q.nv;
        end else if (of) begin
            fflags_d[FF_OF] = 1'b1;
            fflags_d[FF_NX] = 1'b1;
            result_d = to_inf ? {s1_q.sign, {EXP_BITS{1'b1}}, {MAN_BITS{1'b0}}}
                              : {s1_q.sign, {(EXP_BITS-1){1'b1}}, 1'b0, {MAN_BITS{1'b1}}};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe_q <= '0;
            s1_q       <= '0;
            result_q   <= '0;
            fflags_q   <= '0;
        end else begin
            if (ready_in) begin
                vld_pipe_q[1] <= valid_in;
                if (valid_in) s1_q <= s1_d;
            end
            if (s2_load) begin
                vld_pipe_q[2] <= vld_pipe_q[1];
                if (vld_pipe_q[1]) begin
                    result_q <= result_d;
                    fflags_q <= fflags_d;
                end
            end
        end
    end
endmodule

// File: tb/tb_vx_fp_pack.sv
// Randomized + directed bench for vx_fp_pack (F32) with an integer-arithmetic reference model.
module tb_vx_fp_pack;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        valid_in, ready_in, sign_in, valid_out, ready_out;
    logic [9:0]  exp_in;
    logic [26:0] man_in;
    logic [6:0]  class_in;
    logic [2:0]  frm_in;
    logic [31:0] result_out;
    logic [4:0]  fflags_out;

    localparam logic [6:0] C_NORM = 7'b1000000, C_SUB = 7'b0010000, C_ZERO = 7'b0100000;
    localparam logic [6:0] C_INF = 7'b0001000, C_SNAN = 7'b0000101, C_QNAN = 7'b0000110;
    localparam logic [26:0] ONE = 27'h4000000;

    vx_fp_pack dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
        .sign_in(sign_in), .exp_in(exp_in), .man_in(man_in), .class_in(class_in),
        .frm_in(frm_in), .valid_out(valid_out), .ready_out(ready_out),
        .result_out(result_out), .fflags_out(fflags_out)
    );

    always #5 clk = ~clk;

    int          vecs = 0, errs = 0, n_out = 0;
    bit          rdy_rand = 0;
    logic [36:0] cur_exp;
    string       cur_tag;
    logic [36:0] sb[$];
    string       sbtag[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: value = M * 2^(e - bias) with M = 1.f; rounding decided by comparing
    // the discarded remainder against one half ulp.
    function automatic logic [36:0] model(input logic s, input logic [9:0] e, input logic [26:0] m,
                                          input logic [6:0] c, input logic [2:0] f);
        int ex, k, rem, fm;
        longint q;
        bit st, tiny, up, nx, inf;
        if (c[2]) return {1'b0, 8'hFF, 1'b1, 22'h0, c[0], 4'b0};
        if (c[3]) return {s, 8'hFF, 23'h0, 5'h0};
        if (c[5]) return {s, 31'h0, 5'h0};
        ex = int'($signed(e));
        q = longint'(m); st = 0; tiny = 0;
        if (ex <= 0) begin
            tiny = 1; k = 1 - ex;
            if (k >= 27) begin st = (m != 0); q = 0; end
            else begin st = ((q & ((64'd1 << k) - 1)) != 0); q = q >> k; end
            ex = 0;
        end
        rem = int'(q & 7); if (st) rem = rem | 1;
        q = q >> 3;
        nx = (rem != 0);
        fm = (f > 4) ? 0 : int'(f);
        case (fm)
            0: up = (rem > 4) || (rem == 4 && q[0]);
            1: up = 0;
            2: up = s && nx;
            3: up = !s && nx;
            default: up = (rem >= 4);
        endcase
        q = q + longint'(up);
        if (q >= (64'd1 << 24)) begin q = q >> 1; ex++; end
        else if (tiny && q >= (64'd1 << 23)) ex = 1;
        if (ex >= 255) begin
            inf = (fm == 0) || (fm == 4) || (fm == 3 && !s) || (fm == 2 && s);
            return inf ? {s, 8'hFF, 23'h0, 5'b00101} : {s, 8'hFE, 23'h7FFFFF, 5'b00101};
        end
        return {s, ex[7:0], q[22:0], 3'b000, tiny && nx, nx};
    endfunction

    task automatic send(input logic s, input logic [9:0] e, input logic [26:0] m,
                        input logic [6:0] c, input logic [2:0] f, input logic [36:0] ex, input string tag);
        int n = 0;
        @(negedge clk); #1;
        valid_in = 1; sign_in = s; exp_in = e; man_in = m; class_in = c; frm_in = f;
        cur_exp = ex; cur_tag = tag;
        #1;
        while (!ready_in && n < 200) begin @(negedge clk); #2; n++; end
        if (n >= 200) chk("accept_timeout", 64'(ready_in), 64'd1);
    endtask

    task automatic sendm(input logic s, input logic [9:0] e, input logic [26:0] m,
                         input logic [6:0] c, input logic [2:0] f, input string tag);
        send(s, e, m, c, f, model(s, e, m, c, f), tag);
    endtask

    task automatic idle();
        @(negedge clk); #1 valid_in = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
        if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    // Scoreboard: observe handshakes just before the edge that completes them.
    initial forever begin
        @(negedge clk); #3;
        if (!reset) begin
            if (valid_out && ready_out) begin
                n_out++;
                if (sb.size() == 0) chk("spurious_out", 64'(result_out), 64'hDEAD);
                else begin
                    logic [36:0] e;
                    string t;
                    e = sb.pop_front(); t = sbtag.pop_front();
                    chk({t, "_res"}, 64'(result_out), 64'(e[36:5]));
                    chk({t, "_ff"}, 64'(fflags_out), 64'(e[4:0]));
                end
            end
            if (valid_in && ready_in) begin sb.push_back(cur_exp); sbtag.push_back(cur_tag); end
        end
    end

    initial forever begin
        @(negedge clk); #1;
        if (rdy_rand) ready_out = ($urandom_range(0, 3) != 0);
    end

    initial begin
        int n0;
        valid_in = 0; ready_out = 1; sign_in = 0; exp_in = 0; man_in = 0; class_in = 0; frm_in = 0;
        cur_exp = 0; cur_tag = "";
        #1 reset = 1; #2;
        chk("rst_valid_out", 64'(valid_out), 64'd0);
        chk("rst_result", 64'(result_out), 64'd0);
        chk("rst_fflags", 64'(fflags_out), 64'd0);
        repeat (2) @(negedge clk);
        #1 reset = 0; #1;
        chk("rst_ready_in", 64'(ready_in), 64'd1);

        send(0, 10'd127, ONE, C_NORM, 3'd0, {32'h3F800000, 5'h00}, "one");
        @(negedge clk); #1 valid_in = 0; #1;
        chk("lat_c1", 64'(valid_out), 64'd0);
        @(negedge clk); #2;
        chk("lat_c2", 64'(valid_out), 64'd1);

        send(0, 10'd127, 27'h7FFFFFC, C_NORM, 3'd0, {32'h40000000, 5'h01}, "rne_carry");
        send(0, 10'd127, 27'h7FFFFFC, C_NORM, 3'd1, {32'h3FFFFFFF, 5'h01}, "rtz_trunc");
        send(0, 10'd255, ONE, C_NORM, 3'd1, {32'h7F7FFFFF, 5'h05}, "of_rtz");
        send(0, 10'd255, ONE, C_NORM, 3'd0, {32'h7F800000, 5'h05}, "of_rne");
        send(1, 10'd255, ONE, C_NORM, 3'd3, {32'hFF7FFFFF, 5'h05}, "of_rup_neg");
        send(0, 10'h3FF, ONE, C_SUB, 3'd0, {32'h00200000, 5'h00}, "sub_exact");
        send(0, 10'h3FF, ONE | 27'd1, C_SUB, 3'd3, {32'h00200001, 5'h03}, "sub_rup");
        send(0, 10'd0, 27'h7FFFFFF, C_SUB, 3'd4, {32'h00800000, 5'h03}, "sub_to_norm");
        send(1, 10'h200, ONE, C_SUB, 3'd2, {32'h80000001, 5'h03}, "sub_sat");
        send(0, 10'd0, 27'h0, C_SNAN, 3'd0, {32'h7FC00000, 5'h10}, "snan");
        send(1, 10'd5, ONE, C_QNAN, 3'd0, {32'h7FC00000, 5'h00}, "qnan");
        send(1, 10'd0, 27'h0, C_INF, 3'd0, {32'hFF800000, 5'h00}, "inf_neg");
        send(1, 10'd0, 27'h0, C_ZERO, 3'd0, {32'h80000000, 5'h00}, "zero_neg");
        idle(); drain();

        ready_out = 0;
        sendm(0, 10'd100, ONE | 27'h5, C_NORM, 3'd0, "bp_a");
        sendm(1, 10'd101, ONE | 27'h6, C_NORM, 3'd2, "bp_b");
        @(negedge clk); #2;
        chk("bp_ready_in_low", 64'(ready_in), 64'd0);
        fork begin @(negedge clk); #1 ready_out = 1; end join_none
        sendm(0, 10'd102, ONE | 27'h7, C_NORM, 3'd3, "bp_c");
        sendm(1, 10'd103, ONE | 27'h4, C_NORM, 3'd4, "bp_d");
        idle(); drain();
        chk("bp_count", 64'(n_out), 64'd18);

        ready_out = 0;
        sendm(0, 10'd120, ONE, C_NORM, 3'd0, "rst_e");
        sendm(0, 10'd121, ONE, C_NORM, 3'd0, "rst_f");
        @(negedge clk); #1 valid_in = 0; reset = 1; #1;
        chk("midrst_valid_out", 64'(valid_out), 64'd0);
        chk("midrst_result", 64'(result_out), 64'd0);
        sb.delete(); sbtag.delete(); n0 = n_out;
        @(negedge clk); #1 reset = 0; ready_out = 1;
        repeat (6) @(negedge clk);
        #3 chk("no_stale", 64'(n_out - n0), 64'd0);

        rdy_rand = 1;
        for (int i = 0; i < 400; i++) begin
            int kind, ei;
            logic [6:0] c;
            logic [26:0] m;
            kind = $urandom_range(0, 9);
            m = {1'b1, 26'($urandom)};
            c = C_NORM;
            case ($urandom_range(0, 3))
                0: ei = $urandom_range(250, 300);
                1: ei = -$urandom_range(0, 30);
                default: ei = $urandom_range(1, 254);
            endcase
            if (kind == 0) c = $urandom_range(0, 1) ? C_SNAN : C_QNAN;
            else if (kind == 1) c = C_INF;
            else if (kind == 2) c = C_ZERO;
            else if (kind <= 4) begin
                c = C_SUB;
                ei = ($urandom_range(0, 7) == 0) ? -$urandom_range(30, 500) : -$urandom_range(0, 28);
            end
            if ($urandom_range(0, 4) == 0) idle();
            sendm(1'($urandom), 10'(ei), m, c, 3'($urandom_range(0, 7)), "rnd");
        end
        idle();
        rdy_rand = 0;
        @(negedge clk); #2 ready_out = 1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout got=%0d exp=0", sb.size());
        $fatal(1, "timeout");
    end
endmodule
